// File: rtl/multi_dds.sv
// Multi-channel DDS waveform generator behind a Wishbone slave.
// Each channel owns a phase accumulator, a waveform shaper (saw, triangle,
// square, LFSR noise, DC), a gain shift and a saturating signed offset.
module multi_dds #(
    parameter int NUM_CH      = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int WAVE_WIDTH  = 16
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    input  logic [ADDR_WIDTH-1:0]        wb_addr_i,
    input  logic                         wb_we_i,
    input  logic                         wb_stb_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    output logic                         wb_ack_o,
    output logic [NUM_CH*WAVE_WIDTH-1:0] wave_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ID     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ENABLE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_SYNC   = ADDR_WIDTH'(2);
    localparam logic [31:0]           ID_WORD     = {8'hD5, 16'h0000, 8'(NUM_CH)};

    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [NUM_CH-1:0]     enable_q, enable_d;
    logic [NUM_CH-1:0]     sync_vec;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] ch_rdata [NUM_CH];
    logic                  unused_dat;

    // Only an idle bus (ack low) accepts a strobe, so a held strobe acks every other cycle.
    assign wr_fire    = wb_stb_i & wb_we_i & ~ack_q;
    assign rd_fire    = wb_stb_i & ~wb_we_i & ~ack_q;
    assign unused_dat = ^wb_dat_i;

    // Global ENABLE register and one-shot SYNC strobes.
    always_comb begin
        enable_d = enable_q;
        sync_vec = '0;
        if (wr_fire && (wb_addr_i == ADDR_ENABLE)) begin
            enable_d = wb_dat_i[NUM_CH-1:0];
        end
        if (wr_fire && (wb_addr_i == ADDR_SYNC)) begin
            sync_vec = wb_dat_i[NUM_CH-1:0];
        end
    end

    // Read mux: global registers plus the OR of per-channel decodes (at most one hits).
    always_comb begin
        rdata = '0;
        if (wb_addr_i == ADDR_ID) begin
            rdata = DATA_WIDTH'(ID_WORD);
        end
        if (wb_addr_i == ADDR_ENABLE) begin
            rdata = DATA_WIDTH'(enable_q);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            rdata = rdata | ch_rdata[c];
        end
        ack_d = wb_stb_i & ~ack_q;
        dat_d = rd_fire ? rdata : dat_q;
    end

    // Bus-side state.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            enable_q <= '0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            enable_q <= enable_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [ADDR_WIDTH-1:0] A_MODE = ADDR_WIDTH'(16 + 4 * gi);
        localparam logic [ADDR_WIDTH-1:0] A_TUNE = ADDR_WIDTH'(16 + 4 * gi + 1);
        localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(16 + 4 * gi + 2);
        localparam logic [ADDR_WIDTH-1:0] A_OFFS = ADDR_WIDTH'(16 + 4 * gi + 3);

        logic [2:0]             mode_q, mode_d;
        logic [PHASE_WIDTH-1:0] tune_q, tune_d;
        logic [1:0]             gain_q, gain_d;
        logic [7:0]             duty_q, duty_d;
        logic [WAVE_WIDTH-1:0]  offset_q, offset_d;
        logic [15:0]            lfsr_q, lfsr_d;
        logic [PHASE_WIDTH-1:0] acc_q, acc_d;
        logic [WAVE_WIDTH-1:0]  wave_q, wave_d;
        logic [PHASE_WIDTH:0]   acc_sum;
        logic [WAVE_WIDTH-1:0]  phase;
        logic [WAVE_WIDTH-1:0]  shape;
        logic [WAVE_WIDTH-1:0]  scaled;
        logic [WAVE_WIDTH+1:0]  res;

        // Channel configuration writes.
        always_comb begin
            mode_d   = mode_q;
            tune_d   = tune_q;
            gain_d   = gain_q;
            duty_d   = duty_q;
            offset_d = offset_q;
            if (wr_fire) begin
                if (wb_addr_i == A_MODE) begin
                    mode_d = wb_dat_i[2:0];
                end
                if (wb_addr_i == A_TUNE) begin
                    tune_d = wb_dat_i[PHASE_WIDTH-1:0];
                end
                if (wb_addr_i == A_CTRL) begin
                    gain_d = wb_dat_i[1:0];
                    duty_d = wb_dat_i[15:8];
                end
                if (wb_addr_i == A_OFFS) begin
                    offset_d = wb_dat_i[WAVE_WIDTH-1:0];
                end
            end
        end

        // Phase accumulation; SYNC wins over increment, and the LFSR steps on carry-out.
        always_comb begin
            acc_sum = {1'b0, acc_q} + {1'b0, tune_q};
            acc_d   = acc_q;
            lfsr_d  = lfsr_q;
            if (sync_vec[gi]) begin
                acc_d = '0;
            end else if (enable_q[gi]) begin
                acc_d = acc_sum[PHASE_WIDTH-1:0];
                if (acc_sum[PHASE_WIDTH]) begin
                    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                end
            end
        end

        // Waveform shaping, gain, signed offset and clamp to the unsigned sample range.
        always_comb begin
            phase = acc_q[PHASE_WIDTH-1 -: WAVE_WIDTH];
            case (mode_q)
                3'd0:    shape = phase;
                3'd1:    shape = phase[WAVE_WIDTH-1] ? ~{phase[WAVE_WIDTH-2:0], 1'b0}
                                                     :  {phase[WAVE_WIDTH-2:0], 1'b0};
                3'd2:    shape = (phase[WAVE_WIDTH-1 -: 8] < duty_q) ? '1 : '0;
                3'd3:    shape = WAVE_WIDTH'(lfsr_q);
                default: shape = '0;
            endcase
            scaled = shape >> gain_q;
            res    = {2'b00, scaled} + {{2{offset_q[WAVE_WIDTH-1]}}, offset_q};
            if (!enable_q[gi]) begin
                wave_d = '0;
            end else if (res[WAVE_WIDTH+1]) begin
                wave_d = '0;
            end else if (res[WAVE_WIDTH]) begin
                wave_d = '1;
            end else begin
                wave_d = res[WAVE_WIDTH-1:0];
            end
        end

        // Channel state.
        always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
            if (!wb_rst_i) begin
                mode_q   <= 3'd0;
                tune_q   <= PHASE_WIDTH'(1);
                gain_q   <= 2'd0;
                duty_q   <= 8'h80;
                offset_q <= '0;
                lfsr_q   <= 16'hACE1 ^ 16'(gi);
                acc_q    <= '0;
                wave_q   <= '0;
            end else begin
                mode_q   <= mode_d;
                tune_q   <= tune_d;
                gain_q   <= gain_d;
                duty_q   <= duty_d;
                offset_q <= offset_d;
                lfsr_q   <= lfsr_d;
                acc_q    <= acc_d;
                wave_q   <= wave_d;
            end
        end

        assign ch_rdata[gi] = (wb_addr_i == A_MODE) ? DATA_WIDTH'(mode_q) :
                              (wb_addr_i == A_TUNE) ? DATA_WIDTH'(tune_q) :
                              (wb_addr_i == A_CTRL) ? DATA_WIDTH'({duty_q, 6'b000000, gain_q}) :
                              (wb_addr_i == A_OFFS) ? DATA_WIDTH'(offset_q) : '0;

        assign wave_o[gi*WAVE_WIDTH +: WAVE_WIDTH] = wave_q;
    end

endmodule
